// File: rtl/mesh_nic_if.sv
// Processor and router handshake signals of the mesh NIC.
// The slave side is the NIC; the master side drives the processor and router ports.
interface mesh_nic_if #(parameter int DATA_WIDTH = 64);
    logic [0:1]            addr;
    logic [0:DATA_WIDTH-1] d_in;
    logic [0:DATA_WIDTH-1] d_out;
    logic                  nicEn;
    logic                  nicWrEn;
    logic                  net_so;
    logic                  net_ro;
    logic [0:DATA_WIDTH-1] net_do;
    logic                  net_polarity;
    logic                  net_si;
    logic                  net_ri;
    logic [0:DATA_WIDTH-1] net_di;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/mesh_nic.sv
// Single-packet output and input buffers between the processor NIC port and a mesh router.
// Bit 0 is the MSB (big-endian numbering); status flags sit in bit DATA_WIDTH-1.
module mesh_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 0
) (
    input logic        clk,
    input logic        reset,
    mesh_nic_if.slave  bus
);
    logic [0:DATA_WIDTH-1] out_buf;
    logic [0:DATA_WIDTH-1] in_buf;
    logic                  out_full;
    logic                  in_full;
    logic                  rd;
    logic                  wr;
    logic                  inject;
    logic                  eject;

    assign rd = bus.nicEn & ~bus.nicWrEn;
    assign wr = bus.nicEn & bus.nicWrEn;

    // Injection waits for a router cycle whose VC polarity matches the packet.
    assign inject = reset & out_full & bus.net_ro & (out_buf[VC_BIT] == bus.net_polarity);
    assign eject  = reset & bus.net_si & ~in_full;

    assign bus.net_so = inject;
    assign bus.net_ri = reset & ~in_full;
    assign bus.net_do = reset ? out_buf : '0;

    always_comb begin
        bus.d_out = '0;
        if (reset && rd) begin
            unique case (bus.addr)
                2'b00: bus.d_out = '0;
                2'b01: bus.d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                2'b10: bus.d_out = in_buf;
                2'b11: bus.d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                default: bus.d_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_buf  <= '0;
            out_full <= 1'b0;
            in_buf   <= '0;
            in_full  <= 1'b0;
        end else begin
            // A write in the injection cycle saw out_full==1, so it is dropped.
            if (inject) begin
                out_full <= 1'b0;
            end else if (wr && bus.addr == 2'b00 && !out_full) begin
                out_buf  <= bus.d_in;
                out_full <= 1'b1;
            end

            if (eject) begin
                in_buf  <= bus.net_di;
                in_full <= 1'b1;
            end else if (rd && bus.addr == 2'b10 && in_full) begin
                in_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mesh_nic.sv
// Scoreboard bench for mesh_nic: driver pushes expected outputs, negedge monitor compares.
module tb_mesh_nic;
    logic clk;
    logic reset;

    mesh_nic_if #(.DATA_WIDTH(64)) bus();

    mesh_nic #(.DATA_WIDTH(64), .VC_BIT(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        so;
        logic        ri;
        logic [0:63] dout;
        logic [0:63] pdo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic pol   = 1'b0;

    // Reference model: what the processor and router can observe about each channel.
    logic        m_out_full = 1'b0;
    logic [0:63] m_out_pkt  = '0;
    logic        m_in_full  = 1'b0;
    logic [0:63] m_in_pkt   = '0;

    task automatic step(input logic rst, input logic en, input logic wr, input logic [0:1] a,
                        input logic [0:63] din, input logic ro, input logic si,
                        input logic [0:63] di);
        exp_t e;
        @(posedge clk);
        #1;
        pol = ~pol;
        reset            = rst;
        bus.nicEn        = en;
        bus.nicWrEn      = wr;
        bus.addr         = a;
        bus.d_in         = din;
        bus.net_ro       = ro;
        bus.net_polarity = pol;
        bus.net_si       = si;
        bus.net_di       = di;
        cyc++;

        e.cyc  = cyc;
        e.so   = 1'b0;
        e.ri   = 1'b0;
        e.dout = '0;
        e.pdo  = '0;
        if (rst) begin
            e.so  = m_out_full && ro && (m_out_pkt[0] == pol);
            e.ri  = !m_in_full;
            e.pdo = m_out_pkt;
            if (en && !wr) begin
                case (a)
                    2'b01: e.dout = m_out_full ? 64'd1 : 64'd0;
                    2'b10: e.dout = m_in_pkt;
                    2'b11: e.dout = m_in_full ? 64'd1 : 64'd0;
                    default: e.dout = '0;
                endcase
            end
        end
        exp_q.push_back(e);

        if (!rst) begin
            m_out_full = 1'b0; m_out_pkt = '0;
            m_in_full  = 1'b0; m_in_pkt  = '0;
        end else begin
            if (e.so) m_out_full = 1'b0;
            else if (en && wr && a == 2'b00 && !m_out_full) begin
                m_out_pkt = din; m_out_full = 1'b1;
            end
            if (si && !m_in_full) begin
                m_in_pkt = di; m_in_full = 1'b1;
            end else if (en && !wr && a == 2'b10 && m_in_full) begin
                m_in_full = 1'b0;
            end
        end
    endtask

    task automatic idle(input logic ro, input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 2'b00, '0, ro, 0, '0);
    endtask

    task automatic rd(input logic [0:1] a);
        step(1, 1, 0, a, '0, 0, 0, '0);
    endtask

    // Monitor: every negedge with a pending expectation compares all four outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.net_so !== e.so) begin
                    fails++;
                    $display("FAIL net_so cyc=%0d got=%b exp=%b", e.cyc, bus.net_so, e.so);
                end
                tests++;
                if (bus.net_ri !== e.ri) begin
                    fails++;
                    $display("FAIL net_ri cyc=%0d got=%b exp=%b", e.cyc, bus.net_ri, e.ri);
                end
                tests++;
                if (bus.d_out !== e.dout) begin
                    fails++;
                    $display("FAIL d_out cyc=%0d got=%h exp=%h", e.cyc, bus.d_out, e.dout);
                end
                if (e.so) begin
                    tests++;
                    if (bus.net_do !== e.pdo) begin
                        fails++;
                        $display("FAIL net_do cyc=%0d got=%h exp=%h", e.cyc, bus.net_do, e.pdo);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus.nicEn = 0; bus.nicWrEn = 0; bus.addr = '0; bus.d_in = '0;
        bus.net_ro = 0; bus.net_polarity = 0; bus.net_si = 0; bus.net_di = '0;

        // Reset, then status reads.
        step(0, 0, 0, 2'b00, '0, 0, 0, '0);
        step(0, 0, 0, 2'b00, '0, 0, 0, '0);
        idle(0, 1);
        rd(2'b01);
        rd(2'b11);

        // Send on polarity 0 only.
        step(1, 1, 1, 2'b00, 64'h0000_0000_0000_00AB, 1, 0, '0);
        idle(1, 3);
        rd(2'b01);

        // Second write while full is dropped.
        step(1, 1, 1, 2'b00, 64'h1, 0, 0, '0);
        step(1, 1, 1, 2'b00, 64'h2, 0, 0, '0);
        rd(2'b01);
        idle(1, 3);
        rd(2'b01);

        // Ejection, pop, status.
        step(1, 0, 0, 2'b00, '0, 0, 1, 64'hDEAD_BEEF_0000_0001);
        rd(2'b11);
        rd(2'b10);
        rd(2'b11);
        rd(2'b10);

        // Write during injection is dropped; ejection captured in the same cycle.
        step(1, 1, 1, 2'b00, 64'h3, 0, 0, '0);
        if (pol == 1'b0) idle(0, 1);
        step(1, 1, 1, 2'b00, 64'h5, 1, 1, 64'h7);
        rd(2'b01);
        rd(2'b11);
        rd(2'b10);

        // Reset while both buffers are full and router is ready.
        step(1, 1, 1, 2'b00, 64'h9, 0, 0, '0);
        rd(2'b10);
        step(1, 0, 0, 2'b00, '0, 0, 1, 64'h11);
        step(0, 0, 0, 2'b00, '0, 1, 1, 64'h22);
        step(0, 0, 0, 2'b00, '0, 1, 0, '0);
        rd(2'b01);
        rd(2'b11);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [0:63] din;
            logic [0:63] di;
            din = {$urandom, $urandom};
            di  = {$urandom, $urandom};
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                 2'($urandom_range(0, 3)), din, ($urandom_range(0, 2) != 0),
                 $urandom_range(0, 1), di);
        end

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mesh_nic.md
Name: mesh_nic

Overview:
- Network interface controller between the four-stage processor's NIC port and one local port of the mesh router.
- Holds one output-channel packet (processor to router) and one input-channel packet (router to processor).
- Exposes both packets plus their status flags as four 2-bit-addressed registers.
- Processor side uses nicEn/nicWrEn/addr handshakes; router side uses send/ready handshakes gated by the network virtual-channel polarity.

Parameters:
- DATA_WIDTH, 64, packet and processor data width.
- VC_BIT, 0, packet bit index carrying the virtual-channel ID compared against net_polarity.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- addr  input  2 [0:1]  register select; 00 out-buffer, 01 out-status, 10 in-buffer, 11 in-status.
- d_in  input  64 [0:63]  processor write data.
- d_out  output  64 [0:63]  processor read data.
- nicEn  input  1  access enable.
- nicWrEn  input  1  1 = write, 0 = read; valid only with nicEn.
- net_so  output  1  send-out to router; net_do valid.
- net_ro  input  1  router ready to accept.
- net_do  output  64  packet to router.
- net_polarity  input  1  router VC polarity; alternates each cycle.
- net_si  input  1  router send-in; net_di valid.
- net_ri  output  1  NIC ready to accept from router.
- net_di  input  64  packet from router.

Behaviour:
- State: out_buf[64], out_full, in_buf[64], in_full.
- Reset (reset==0 at posedge clk):
  - out_buf, in_buf, out_full, in_full all cleared to 0.
  - While reset is low: net_so=0, net_ri=0, d_out=0, net_do=0.
- Processor read (combinational d_out, same cycle as nicEn & !nicWrEn):
  - 00 -> 0.
  - 01 -> {63'b0, out_full}, flag in bit 63.
  - 10 -> in_buf.
  - 11 -> {63'b0, in_full}.
  - nicEn low -> d_out = 0.
- Pop: at posedge with nicEn & !nicWrEn & addr==10 & in_full, in_full <= 0.
  - in_buf keeps its value; no other side effect.
  - Reading 10 while in_full==0 returns stale in_buf and changes no state.
- Processor write: at posedge with nicEn & nicWrEn & addr==00:
  - If out_full==0: out_buf <= d_in, out_full <= 1.
  - If out_full==1: write silently dropped, state unchanged.
  - Writes to 01/10/11 are ignored.
- Injection:
  - net_do = out_buf.
  - net_so = out_full & net_ro & (out_buf[VC_BIT]==net_polarity), combinational.
  - At posedge with net_so==1: out_full <= 0; the packet is transferred in exactly that cycle.
- Simultaneous write to 00 and injection in the same cycle: the write is dropped, because out_full was 1 at decision time. Processor must poll 01 before writing. Next cycle out_full==0.
- Ejection:
  - net_ri = ~in_full (forced 0 during reset).
  - At posedge with net_si & net_ri: in_buf <= net_di, in_full <= 1.
  - net_si while net_ri==0 is ignored; the router must not do this.
- Pop and eject cannot coincide, since net_ri==0 while in_full==1. The earliest refill is the cycle after a pop.
- Latency:
  - write to earliest net_so = 1 cycle, further gated by net_ro and polarity.
  - net_si capture to in-status==1 visible = 1 cycle.
- Reset mid-transfer: an asserted net_so/net_si cycle coinciding with reset==0 transfers nothing; all flags end at 0.
- Out and in channels are fully independent; both may transfer in the same cycle.

Test Plan:
- Reset low 2 cycles then high:
  - net_so=0, net_ri=1 after release.
  - read 01 -> 0, read 11 -> 0.
- Write 00 with 64'h0000_0000_0000_00AB (bit0=0), net_ro=1:
  - net_so asserts only in cycles with net_polarity=0.
  - net_do=64'hAB on that cycle.
  - next cycle out-status reads 0.
- Write 00 = 64'h1 while net_ro=0, then write 00 = 64'h2:
  - status 01 reads 1.
  - second write dropped.
  - on net_ro=1 with matching polarity, net_do=64'h1.
- Router drives net_si=1, net_di=64'hDEAD_BEEF_0000_0001:
  - next cycle net_ri=0 and read 11 -> 1.
  - read 10 -> DEAD_BEEF_0000_0001.
  - after that pop, net_ri=1 and 11 reads 0.
- Simultaneous: out_full=1 and net_so fires while processor writes 00=64'h5:
  - write dropped, out-status reads 0 next cycle.
  - in the same cycle, a router ejection of 64'h7 is captured.
- Assert reset low while out_full=1, in_full=1, net_ro=1:
  - no injection occurs.
  - both status registers read 0 after release.
